// File: rtl/disp_arbiter_pkg.sv
// Shared types and helpers for the display arbiter: state encoding, sizes,
// and the round-robin winner search.
package disp_arbiter_pkg;

  localparam int NREQ   = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan downward so the closest candidate after 'last' is written last and wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [IDX_W-1:0] last);
    pick_t            p;
    logic [IDX_W-1:0] idx;
    p = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester/display bundle between the arbiter and its users; the arbiter
// takes the slave side, requesters and the scan driver sit on the master side.
interface disp_arbiter_if;
  import disp_arbiter_pkg::*;

  logic [NREQ-1:0]   req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  owner;
  logic [DATA_W-1:0] disp_x;
  logic              disp_valid;
  logic              tick;

  modport master (
    output req, data0, data1, data2, data3,
    input  grant, owner, disp_x, disp_valid, tick
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output grant, owner, disp_x, disp_valid, tick
  );

endinterface

// File: rtl/disp_arbiter_tick_gen.sv
// Free-running prescaler producing a one-cycle dwell tick every PRESC clocks.
module tick_gen #(
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Decoded from the count register, so it drops to zero the moment reset asserts.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner arbitration for a shared 4-digit display: the owner keeps
// the display for DWELL ticks before others may pre-empt, with a 1-cycle gap.
module disp_arbiter
  import disp_arbiter_pkg::*;
#(
  parameter int PRESC = 4,
  parameter int DWELL = 3
) (
  input  logic           clk,
  input  logic           clr_n,
  disp_arbiter_if.slave  bus
);

  localparam int DWW = $clog2(DWELL + 1);
  localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL);

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [IDX_W-1:0]  owner_q;
  logic [DATA_W-1:0] disp_x_q;
  logic              disp_valid_q;
  logic [DWW-1:0]    dwell_q;

  logic              tick_w;
  pick_t             pick_d;
  logic [DATA_W-1:0] data_sel_d;
  logic              others_req_d;
  logic              dwell_done_d;

  tick_gen #(.PRESC(PRESC)) u_tick_gen (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick_w)
  );

  always_comb begin
    data_sel_d = bus.data0;
    case (owner_q)
      2'd1:    data_sel_d = bus.data1;
      2'd2:    data_sel_d = bus.data2;
      2'd3:    data_sel_d = bus.data3;
      default: data_sel_d = bus.data0;
    endcase
  end

  assign pick_d       = rr_pick(bus.req, owner_q);
  assign others_req_d = |(bus.req & ~onehot(owner_q));
  assign dwell_done_d = (dwell_q == DWELL_MAX);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= IDX_W'(NREQ - 1);
      disp_x_q     <= '0;
      disp_valid_q <= 1'b0;
      dwell_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          disp_x_q     <= '0;
          disp_valid_q <= 1'b0;
          if (pick_d.found) begin
            state_q <= OWN;
            grant_q <= onehot(pick_d.idx);
            owner_q <= pick_d.idx;
            dwell_q <= '0;
          end
        end
        OWN: begin
          disp_x_q <= data_sel_d;
          if (tick_w && !dwell_done_d) begin
            dwell_q <= dwell_q + DWW'(1);
          end
          // A dropped request and an expired dwell lead to the same GAP entry.
          if (!bus.req[owner_q] || (dwell_done_d && others_req_d)) begin
            state_q      <= GAP;
            grant_q      <= '0;
            disp_valid_q <= 1'b0;
          end else begin
            disp_valid_q <= 1'b1;
          end
        end
        GAP: begin
          disp_valid_q <= 1'b0;
          if (pick_d.found) begin
            state_q <= OWN;
            grant_q <= onehot(pick_d.idx);
            owner_q <= pick_d.idx;
            dwell_q <= '0;
          end else begin
            state_q  <= IDLE;
            disp_x_q <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          grant_q      <= '0;
          disp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner      = owner_q;
  assign bus.disp_x     = disp_x_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.tick       = tick_w;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter at PRESC=4, DWELL=3; expected values are
// hand-derived from edge numbers counted since each reset release.
module tb_disp_arbiter;

  logic clk;
  logic clr_n;
  int   checks;
  int   passed;
  logic [15:0] v;

  disp_arbiter_if bus ();

  disp_arbiter #(.PRESC(4), .DWELL(3)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    v      = '0;
    clr_n  = 1'b0;
    bus.req   = 4'b0000;
    bus.data0 = 16'h0000;
    bus.data1 = 16'h0000;
    bus.data2 = 16'h0000;
    bus.data3 = 16'h0000;

    // Reset state
    #12;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_owner", 32'(bus.owner), 32'h3);
    check("rst_disp_x", 32'(bus.disp_x), 32'h0);
    check("rst_valid", 32'(bus.disp_valid), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);

    // Idle with no requests
    @(negedge clk);
    clr_n = 1'b1;
    step();
    step();
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_valid", 32'(bus.disp_valid), 32'h0);

    // Single requester 0: grant after 1 clk, data after 2 clk
    bus.req   = 4'b0001;
    bus.data0 = 16'h1234;
    step();
    check("first_grant", 32'(bus.grant), 32'h1);
    check("first_owner", 32'(bus.owner), 32'h0);
    check("first_valid", 32'(bus.disp_valid), 32'h0);
    step();
    check("second_disp_x", 32'(bus.disp_x), 32'h1234);
    check("second_valid", 32'(bus.disp_valid), 32'h1);

    // Sole requester keeps the display; disp_x follows data0 one cycle late
    for (int i = 0; i < 100; i++) begin
      v = 16'(i * 16'h0137 + 16'h0005);
      bus.data0 = v;
      step();
      check("hold_grant", 32'(bus.grant), 32'h1);
      check("hold_valid", 32'(bus.disp_valid), 32'h1);
      check("hold_disp_x", 32'(bus.disp_x), 32'(v));
    end

    // Drop: GAP holds disp_x, then IDLE clears it
    bus.req = 4'b0000;
    step();
    check("drop_gap_grant", 32'(bus.grant), 32'h0);
    check("drop_gap_valid", 32'(bus.disp_valid), 32'h0);
    check("drop_gap_disp_x", 32'(bus.disp_x), 32'(v));
    step();
    check("drop_idle_disp_x", 32'(bus.disp_x), 32'h0);
    check("drop_idle_owner", 32'(bus.owner), 32'h0);

    // Fresh reset, then req=0011: owner 0 for 12 clk, one GAP, then owner 1
    @(negedge clk);
    clr_n = 1'b0;
    bus.req   = 4'b0011;
    bus.data0 = 16'hAAAA;
    bus.data1 = 16'hBBBB;
    bus.data2 = 16'hCCCC;
    bus.data3 = 16'hDDDD;
    @(negedge clk);
    clr_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      check("dwell_grant", 32'(bus.grant), 32'h1);
      check("dwell_tick", 32'(bus.tick), (e % 4 == 3) ? 32'h1 : 32'h0);
    end
    step();  // E13
    check("pre_gap_grant", 32'(bus.grant), 32'h0);
    check("pre_gap_valid", 32'(bus.disp_valid), 32'h0);
    check("pre_gap_disp_x", 32'(bus.disp_x), 32'hAAAA);
    check("pre_gap_owner", 32'(bus.owner), 32'h0);
    step();  // E14
    check("pre_new_grant", 32'(bus.grant), 32'h2);
    check("pre_new_owner", 32'(bus.owner), 32'h1);
    check("pre_new_valid", 32'(bus.disp_valid), 32'h0);
    step();  // E15
    check("pre_new_disp_x", 32'(bus.disp_x), 32'hBBBB);
    check("pre_new_valid2", 32'(bus.disp_valid), 32'h1);

    // Owner 1 drops; requester 2 takes over
    bus.req = 4'b0100;
    step();  // E16
    check("drop1_gap", 32'(bus.grant), 32'h0);
    step();  // E17
    check("own2_grant", 32'(bus.grant), 32'h4);

    // Owner 2 drops after one tick while 0 and 3 wait: round-robin picks 3
    bus.req = 4'b1101;
    step();  // E18
    step();  // E19
    check("own2_tick", 32'(bus.tick), 32'h1);
    step();  // E20
    check("own2_hold", 32'(bus.grant), 32'h4);
    bus.req = 4'b1001;
    step();  // E21
    check("drop2_gap_grant", 32'(bus.grant), 32'h0);
    check("drop2_gap_owner", 32'(bus.owner), 32'h2);
    step();  // E22
    check("rr_after2_grant", 32'(bus.grant), 32'h8);
    check("rr_after2_owner", 32'(bus.owner), 32'h3);

    // Owner 3 drops with req=0110: owner 1 next
    bus.req = 4'b0110;
    step();  // E23
    check("drop3_gap", 32'(bus.grant), 32'h0);
    step();  // E24
    check("own1_grant", 32'(bus.grant), 32'h2);
    for (int e = 25; e <= 35; e++) begin
      step();
      check("own1_hold", 32'(bus.grant), 32'h2);
    end
    // Tick cycle in which dwell reaches DWELL: owner 1 drops at the same time
    check("expire_tick", 32'(bus.tick), 32'h1);
    bus.req = 4'b0100;
    step();  // E36
    check("expire_gap_grant", 32'(bus.grant), 32'h0);
    check("expire_gap_valid", 32'(bus.disp_valid), 32'h0);
    step();  // E37
    check("expire_new_grant", 32'(bus.grant), 32'h4);
    check("expire_new_owner", 32'(bus.owner), 32'h2);
    step();  // E38
    check("expire_single_gap", 32'(bus.grant), 32'h4);

    // Asynchronous reset mid-OWN, between clock edges
    #3;
    clr_n = 1'b0;
    #1;
    check("async_grant", 32'(bus.grant), 32'h0);
    check("async_valid", 32'(bus.disp_valid), 32'h0);
    check("async_owner", 32'(bus.owner), 32'h3);
    check("async_disp_x", 32'(bus.disp_x), 32'h0);
    check("async_tick", 32'(bus.tick), 32'h0);
    @(negedge clk);
    bus.req = 4'b1111;
    clr_n   = 1'b1;
    step();
    check("post_rst_grant", 32'(bus.grant), 32'h1);
    check("post_rst_owner", 32'(bus.owner), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter PRESC, default 4: clk cycles per dwell tick, at least 2.
REQ-002 Parameter DWELL, default 3: ticks a grantee owns the display before it can be pre-empted, at least 1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 clr_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  4  per-requester level request; bit i = requester i.
REQ-006 data0..data3  input  16 each  hex value requester i wants shown, sampled every cycle while granted.
REQ-007 grant  output  4  one-hot owner indication; all-zero when no owner.
REQ-008 owner  output  2  index of current owner; holds last owner when grant is zero.
REQ-009 disp_x  output  16  value for the 4-digit seven-segment scanner.
REQ-010 disp_valid  output  1  high while disp_x carries owner data; scanner blanks when low.
REQ-011 tick  output  1  one-cycle dwell-tick pulse.

Function
REQ-012 Prescaler counts 0..PRESC-1 and wraps; tick is high for the cycle in which the count equals PRESC-1.
REQ-013 The prescaler is free-running and independent of FSM state.
REQ-014 FSM states are IDLE, OWN and GAP.
REQ-015 IDLE: grant=0, disp_valid=0, disp_x=0.
REQ-016 IDLE exit: if any req bit is set, pick a winner and enter OWN next cycle with grant set.
REQ-017 Winner selection is round-robin: the first set req bit scanning upward, with wrap, from (owner+1) mod 4.
REQ-018 OWN: disp_x is data[owner], registered, so disp_x lags data by 1 cycle.
REQ-019 OWN: disp_valid=1 from the second OWN cycle onward; the first OWN cycle shows disp_valid=0.
REQ-020 Dwell counter clears on entry to OWN and increments on each tick, saturating at DWELL.
REQ-021 OWN to GAP when req[owner] deasserts, whatever the dwell count.
REQ-022 OWN to GAP when the dwell count equals DWELL and any other req bit is set.
REQ-023 When the dwell count equals DWELL and no other req bit is set, the owner keeps the display indefinitely.
REQ-024 If the owner drops req in the same cycle dwell expires, the drop rule governs; the outcome is the same transition.
REQ-025 GAP lasts exactly 1 cycle with grant=0, disp_valid=0 and disp_x holding its last value.
REQ-026 GAP exit: arbitrate per REQ-017 and enter OWN if any req is set, else go to IDLE.
REQ-027 A requester re-asserting req during GAP is eligible in that GAP's arbitration.
REQ-028 grant is never multi-hot; at most one owner change occurs per GAP.

Reset
REQ-029 While clr_n=0: FSM=IDLE, grant=0, owner=3 (so requester 0 wins first), disp_x=0, disp_valid=0, tick=0, prescaler=0, dwell=0.
REQ-030 Reset asserted mid-OWN forces the reset values immediately, without waiting for a clock edge.
REQ-031 After reset release, the first arbitration happens on the first rising edge with req nonzero.

Structure
REQ-032 A shared package holds the state encoding (IDLE=0, OWN=1, GAP=2), NREQ=4 and the data width of 16.
REQ-033 The prescaler is a separate sub-module, tick_gen, parameterised by PRESC, with outputs tick only.
REQ-034 disp_x and disp_valid connect directly to the existing 7-segment scan driver's x input and its blanking enable.

Verification
REQ-035 Reset then req=0001, data0=1234: grant=0001 after 1 clk; disp_x=1234 with disp_valid=1 after 2 clk.
REQ-036 req=0011 held, requester 0 owning: owner switches to 1 exactly after 3 ticks (12 clk at PRESC=4), with one GAP cycle between.
REQ-037 req=0001 only, held 100 clk: grant stays 0001 and disp_valid stays 1 throughout.
REQ-038 Owner 2 drops req after 1 tick while req=1101: GAP, then grant=1000 (round-robin after 2).
REQ-039 clr_n pulled low mid-OWN, asynchronous to clk: grant=0 and disp_valid=0 before the next edge; after release, req=1111 gives grant=0001.
REQ-040 Owner drops req in the tick cycle in which dwell reaches DWELL, with req=0110 and owner 1: exactly one GAP, then grant=0100.
